// File: rtl/rsa_pkg.sv
// Shared encodings for the RSA operand loader: host commands, controller states, word count.
package rsa_pkg;

  localparam int WORDS = 16;

  typedef enum logic [1:0] {
    CMD_LD_M  = 2'd0,
    CMD_LD_E  = 2'd1,
    CMD_LD_N  = 2'd2,
    CMD_START = 2'd3
  } cmd_e;

  typedef enum logic [2:0] {
    ST_FLUSH    = 3'd0,
    ST_IDLE     = 3'd1,
    ST_REQ      = 3'd2,
    ST_FEED     = 3'd3,
    ST_WAIT_VLD = 3'd4,
    ST_CSTART   = 3'd5,
    ST_CWAIT    = 3'd6
  } state_e;

endpackage

// File: rtl/rsa_load_ctrl_if.sv
// Host command, deserializer and RSA core signals seen by rsa_load_ctrl.
// master = the controller, slave = everything around it (host, seq_to_para, core).
interface rsa_load_ctrl_if #(
  parameter int RSA_LEN = 512
);
  logic               cmd_valid;
  logic [1:0]         cmd_sel;
  logic               cmd_ready;
  logic               des_rdy;
  logic               data_req;
  logic [RSA_LEN-1:0] des_data;
  logic               des_vld;
  logic [RSA_LEN-1:0] op_m;
  logic [RSA_LEN-1:0] op_e;
  logic [RSA_LEN-1:0] op_n;
  logic               core_start;
  logic               core_done;
  logic [RSA_LEN-1:0] core_res;
  logic [RSA_LEN-1:0] res;
  logic               res_vld;
  logic               err;
  logic               busy;

  modport master (
    input  cmd_valid, cmd_sel, des_data, des_vld, core_done, core_res,
    output cmd_ready, des_rdy, data_req, op_m, op_e, op_n,
           core_start, res, res_vld, err, busy
  );

  modport slave (
    output cmd_valid, cmd_sel, des_data, des_vld, core_done, core_res,
    input  cmd_ready, des_rdy, data_req, op_m, op_e, op_n,
           core_start, res, res_vld, err, busy
  );
endinterface

// File: rtl/rsa_load_ctrl.sv
// Sequences the shared seq_to_para deserializer to load M/E/N, then starts the RSA core and captures its result.
// Latency: load handshake T -> des_rdy T+1, data_req T+2..T+17, operand + cmd_ready T+19; start -> core_start T+2.
// Backpressure: one command in flight; cmd_ready low outside IDLE and for FLUSH_CYC cycles after reset.
module rsa_load_ctrl
  import rsa_pkg::*;
#(
  parameter int RSA_LEN   = 512,
  parameter int BUS_W     = 32,
  parameter int VLD_SLACK = 4,
  parameter int FLUSH_CYC = 18
) (
  input  logic            clk,
  input  logic            rst,
  rsa_load_ctrl_if.master bus
);

  if (RSA_LEN / BUS_W != WORDS) begin : g_bad_width
    $error("rsa_load_ctrl: RSA_LEN/BUS_W must equal the deserializer word count");
  end

  localparam logic [4:0] FLUSH_LAST = 5'(FLUSH_CYC - 1);
  localparam logic [4:0] FEED_LAST  = 5'(WORDS - 1);
  localparam logic [4:0] VLD_LAST   = 5'(VLD_SLACK);

  state_e             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  cmd_e               sel_q, sel_d;
  logic               ld_m_q, ld_e_q, ld_n_q;
  logic [RSA_LEN-1:0] op_m_q, op_e_q, op_n_q, res_q;
  logic               res_vld_q, des_rdy_q, data_req_q, core_start_q, err_q;
  logic               busy_q, cmd_ready_q;

  logic accept, capture, timeout, start_ok, start_err, res_cap;
  logic all_loaded;

  assign all_loaded = ld_m_q & ld_e_q & ld_n_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    accept    = 1'b0;
    capture   = 1'b0;
    timeout   = 1'b0;
    start_ok  = 1'b0;
    start_err = 1'b0;
    res_cap   = 1'b0;
    case (state_q)
      // The deserializer counter has no reset, so give it time to run out any stale sequence.
      ST_FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          accept  = 1'b1;
          sel_d   = cmd_e'(bus.cmd_sel);
          cnt_d   = '0;
          state_d = (cmd_e'(bus.cmd_sel) == CMD_START) ? ST_CSTART : ST_REQ;
        end
      end
      ST_REQ: begin
        state_d = ST_FEED;
        cnt_d   = '0;
      end
      ST_FEED: begin
        if (cnt_q == FEED_LAST) begin
          state_d = ST_WAIT_VLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      ST_WAIT_VLD: begin
        if (bus.des_vld) begin
          capture = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == VLD_LAST) begin
          timeout = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      // Missing operands: hold one extra cycle while err is out so cmd_ready follows it.
      ST_CSTART: begin
        if (err_q) begin
          state_d = ST_IDLE;
        end else if (all_loaded) begin
          start_ok = 1'b1;
          state_d  = ST_CWAIT;
        end else begin
          start_err = 1'b1;
        end
      end
      ST_CWAIT: begin
        if (bus.core_done) begin
          res_cap = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_FLUSH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_FLUSH;
      cnt_q        <= '0;
      sel_q        <= CMD_LD_M;
      ld_m_q       <= 1'b0;
      ld_e_q       <= 1'b0;
      ld_n_q       <= 1'b0;
      op_m_q       <= '0;
      op_e_q       <= '0;
      op_n_q       <= '0;
      res_q        <= '0;
      res_vld_q    <= 1'b0;
      des_rdy_q    <= 1'b0;
      data_req_q   <= 1'b0;
      core_start_q <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b1;
      cmd_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      // Status outputs are registered from the next state so they line up with it.
      cmd_ready_q  <= (state_d == ST_IDLE);
      busy_q       <= (state_d != ST_IDLE);
      des_rdy_q    <= (state_d == ST_REQ);
      data_req_q   <= (state_d == ST_FEED);
      core_start_q <= start_ok;
      err_q        <= timeout | start_err;
      if (capture) begin
        case (sel_q)
          CMD_LD_M: begin op_m_q <= bus.des_data; ld_m_q <= 1'b1; end
          CMD_LD_E: begin op_e_q <= bus.des_data; ld_e_q <= 1'b1; end
          CMD_LD_N: begin op_n_q <= bus.des_data; ld_n_q <= 1'b1; end
          default: ;
        endcase
      end
      if (accept) begin
        res_vld_q <= 1'b0;
      end
      if (res_cap) begin
        res_q     <= bus.core_res;
        res_vld_q <= 1'b1;
      end
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.busy       = busy_q;
  assign bus.des_rdy    = des_rdy_q;
  assign bus.data_req   = data_req_q;
  assign bus.core_start = core_start_q;
  assign bus.err        = err_q;
  assign bus.op_m       = op_m_q;
  assign bus.op_e       = op_e_q;
  assign bus.op_n       = op_n_q;
  assign bus.res        = res_q;
  assign bus.res_vld    = res_vld_q;

endmodule

// File: tb/tb_rsa_load_ctrl.sv
// Directed bench for rsa_load_ctrl; the bench plays host, deserializer and RSA core.
module tb_rsa_load_ctrl;
  import rsa_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  rsa_load_ctrl_if #(.RSA_LEN(512)) bus ();

  rsa_load_ctrl #(
    .RSA_LEN(512), .BUS_W(32), .VLD_SLACK(4), .FLUSH_CYC(18)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  localparam logic [511:0] N_WORDS = 512'h00000010_0000000f_0000000e_0000000d_0000000c_0000000b_0000000a_00000009_00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("wait_ready", bus.cmd_ready, 1);
  endtask

  // Cycle T is the handshake; returns in T+19 (vld given) or T+24 (vld withheld).
  task automatic load(input logic [1:0] sel, input logic [511:0] val, input bit give_vld);
    wait_ready();
    bus.cmd_valid = 1'b1;
    bus.cmd_sel   = sel;
    step();
    bus.cmd_valid = 1'b0;
    chk("ld_des_rdy_T1", bus.des_rdy, 1);
    chk("ld_ready_T1", bus.cmd_ready, 0);
    chk("ld_data_req_T1", bus.data_req, 0);
    step();
    chk("ld_des_rdy_T2", bus.des_rdy, 0);
    for (int k = 0; k < 16; k++) begin
      chk("ld_data_req_feed", bus.data_req, 1);
      step();
    end
    chk("ld_data_req_T18", bus.data_req, 0);
    if (give_vld) begin
      bus.des_vld  = 1'b1;
      bus.des_data = val;
      step();
      bus.des_vld  = 1'b0;
      bus.des_data = '0;
      chk("ld_ready_T19", bus.cmd_ready, 1);
      chk("ld_err_T19", bus.err, 0);
    end else begin
      for (int i = 0; i < 5; i++) begin
        chk("to_err_early", bus.err, 0);
        step();
      end
      chk("to_err_T23", bus.err, 1);
      chk("to_ready_T23", bus.cmd_ready, 1);
      step();
      chk("to_err_pulse", bus.err, 0);
    end
  endtask

  task automatic start(input bit expect_ok, input logic [511:0] resv);
    wait_ready();
    bus.cmd_valid = 1'b1;
    bus.cmd_sel   = CMD_START;
    step();
    bus.cmd_valid = 1'b0;
    chk("st_res_vld_clr_T1", bus.res_vld, 0);
    chk("st_busy_T1", bus.busy, 1);
    chk("st_core_start_T1", bus.core_start, 0);
    step();
    if (expect_ok) begin
      chk("st_core_start_T2", bus.core_start, 1);
      chk("st_err_T2", bus.err, 0);
      step();
      chk("st_core_start_pulse", bus.core_start, 0);
      for (int i = 0; i < 9; i++) step();
      chk("st_ready_cwait", bus.cmd_ready, 0);
      chk("st_res_vld_cwait", bus.res_vld, 0);
      bus.core_done = 1'b1;
      bus.core_res  = resv;
      step();
      bus.core_done = 1'b0;
      bus.core_res  = 512'hbad;
      chk("st_res", bus.res, resv);
      chk("st_res_vld", bus.res_vld, 1);
      chk("st_ready_done", bus.cmd_ready, 1);
    end else begin
      chk("st_err_T2", bus.err, 1);
      chk("st_no_core_start", bus.core_start, 0);
      chk("st_ready_T2", bus.cmd_ready, 0);
      step();
      chk("st_ready_T3", bus.cmd_ready, 1);
      chk("st_err_T3", bus.err, 0);
      chk("st_no_core_start_T3", bus.core_start, 0);
    end
  endtask

  task automatic check_flush();
    chk("rst_busy", bus.busy, 1);
    chk("rst_op_m", bus.op_m, 0);
    chk("rst_op_e", bus.op_e, 0);
    chk("rst_op_n", bus.op_n, 0);
    chk("rst_res", bus.res, 0);
    chk("rst_res_vld", bus.res_vld, 0);
    chk("rst_des_rdy", bus.des_rdy, 0);
    chk("rst_data_req", bus.data_req, 0);
    chk("rst_core_start", bus.core_start, 0);
    chk("rst_err", bus.err, 0);
    for (int i = 0; i < 18; i++) begin
      chk("flush_ready_low", bus.cmd_ready, 0);
      step();
    end
    chk("flush_ready_high", bus.cmd_ready, 1);
    chk("flush_busy_low", bus.busy, 0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_sel   = 2'd0;
    bus.des_vld   = 1'b0;
    bus.des_data  = '0;
    bus.core_done = 1'b0;
    bus.core_res  = '0;
    rst = 1'b1;
    step(); step(); step();
    rst = 1'b0;
    check_flush();

    // Strays outside their windows must be ignored.
    bus.core_done = 1'b1;
    bus.core_res  = 512'hdead;
    bus.des_vld   = 1'b1;
    bus.des_data  = 512'hbeef;
    step();
    bus.core_done = 1'b0;
    bus.des_vld   = 1'b0;
    step();
    chk("stray_res_vld", bus.res_vld, 0);
    chk("stray_res", bus.res, 0);
    chk("stray_op_m", bus.op_m, 0);

    load(CMD_LD_M, 512'd2, 1'b1);
    chk("m_loaded", bus.op_m, 512'd2);
    load(CMD_LD_E, 512'd3, 1'b1);
    chk("e_loaded", bus.op_e, 512'd3);
    chk("e_keeps_m", bus.op_m, 512'd2);
    start(1'b0, '0);

    load(CMD_LD_N, N_WORDS, 1'b1);
    chk("n_words", bus.op_n, N_WORDS);
    chk("n_keeps_m", bus.op_m, 512'd2);
    chk("n_keeps_e", bus.op_e, 512'd3);
    load(CMD_LD_N, 512'd5, 1'b1);
    chk("n_reload", bus.op_n, 512'd5);

    start(1'b1, 512'd3);
    load(CMD_LD_M, 512'd2, 1'b1);
    chk("res_vld_cleared", bus.res_vld, 0);
    chk("res_kept", bus.res, 512'd3);
    start(1'b1, 512'd7);

    // Reset in FEED cycle 7.
    wait_ready();
    bus.cmd_valid = 1'b1;
    bus.cmd_sel   = CMD_LD_E;
    step();
    bus.cmd_valid = 1'b0;
    step();
    for (int i = 0; i < 7; i++) step();
    chk("feed7_data_req", bus.data_req, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_data_req", bus.data_req, 0);
    chk("rst_mid_ready", bus.cmd_ready, 0);
    check_flush();
    load(CMD_LD_M, 512'd9, 1'b1);
    chk("post_rst_m", bus.op_m, 512'd9);

    load(CMD_LD_E, 512'd7, 1'b0);
    chk("withheld_e", bus.op_e, 0);
    load(CMD_LD_N, 512'd5, 1'b1);
    start(1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rsa_load_ctrl.md
# rsa_load_ctrl

Command-driven controller that sequences the shared 32→512-bit `seq_to_para` deserializer for the RSA datapath. It loads message, exponent and modulus into three operand registers, one host command at a time. It also starts the RSA core and captures its result. The block sits between the host bus interface and the RSA core; the deserializer instance sits beside it, with the host data bus wired straight to the deserializer's `data_in`.

## Interface
- `RSA_LEN`, 512: operand width in bits.
- `BUS_W`, 32: host word width. `RSA_LEN/BUS_W` must equal 16, which is the fixed word count of the deserializer.
- `VLD_SLACK`, 4: extra cycles allowed for `des_vld` before a load error is declared.
- `FLUSH_CYC`, 18: cycles `cmd_ready` is held low after reset.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  host command strobe.
- `cmd_sel`  in  2  0 = load M, 1 = load E, 2 = load N, 3 = start.
- `cmd_ready`  out  1  command accepted on `cmd_valid & cmd_ready`.
- `des_rdy`  out  1  one-cycle kick to the deserializer `rdy` input.
- `data_req`  out  1  host must present the next word on the bus in this cycle.
- `des_data`  in  RSA_LEN  deserializer `data_out`.
- `des_vld`  in  1  deserializer `vld`.
- `op_m`, `op_e`, `op_n`  out  RSA_LEN  operand registers.
- `core_start`  out  1  one-cycle start pulse to the RSA core.
- `core_done`  in  1  core completion pulse.
- `core_res`  in  RSA_LEN  core result.
- `res`  out  RSA_LEN  captured result.
- `res_vld`  out  1  `res` is valid.
- `err`  out  1  one-cycle error pulse.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states:
  - FLUSH → IDLE.
  - IDLE → REQ → FEED → WAIT_VLD → IDLE (load path).
  - IDLE → CSTART → CWAIT → IDLE (start path).
- FLUSH:
  - Entered on reset and held for `FLUSH_CYC` cycles, because the deserializer's internal counter is not reset and may still be mid-sequence.
  - `cmd_ready` = 0 throughout.
- IDLE:
  - `cmd_ready` = 1.
  - A handshake latches `cmd_sel` and clears `res_vld`.
  - sel 0–2 → REQ; sel 3 → CSTART.
- REQ: `des_rdy` = 1 for exactly one cycle.
- FEED:
  - 16 cycles with `data_req` = 1.
  - Word k (k = 0..15) sent in FEED cycle k lands in bits [32k+31:32k]; word 0 is least significant.
- WAIT_VLD:
  - On `des_vld`, copy `des_data` into the selected operand register and set its loaded flag.
  - If `des_vld` does not arrive within 1+`VLD_SLACK` cycles: pulse `err`, leave the register and flag unchanged, go to IDLE.
- CSTART:
  - If not all three loaded flags are set: pulse `err`, no `core_start`, go to IDLE.
  - Otherwise pulse `core_start` and go to CWAIT.
- CWAIT:
  - Wait indefinitely for `core_done`.
  - On `core_done`: `res` ← `core_res`, `res_vld` ← 1, go to IDLE.
- Loaded flags persist across starts. Reloading an operand overwrites it.
- `core_done` outside CWAIT and `des_vld` outside WAIT_VLD are ignored.
- `cmd_valid` while `cmd_ready` = 0 is not accepted; the host holds it.

## Timing
- All outputs are registered.
- Reset values: `op_m`, `op_e`, `op_n`, `res` = 0. `res_vld`, `des_rdy`, `data_req`, `core_start`, `err` = 0. `busy` = 1 and `cmd_ready` = 0 during FLUSH. Loaded flags = 0.
- Load latency, with the handshake in cycle T:
  - `des_rdy` high in T+1.
  - `data_req` high T+2..T+17.
  - `des_vld` expected in T+18.
  - Operand updated and visible in T+19.
  - `cmd_ready` high again in T+19.
- Start with all operands loaded: `core_start` high in T+2. `res`/`res_vld` become visible one cycle after `core_done` is sampled; `cmd_ready` also returns in that cycle.
- Start with operands missing: `err` pulses in T+2 and `cmd_ready` returns in T+3.
- Reset mid-operation (any state): next cycle in FLUSH, all registers reset, no `des_rdy`/`core_start` issued.

## Structure
- Shared package `rsa_pkg` holds:
  - command encodings `CMD_LD_M`/`CMD_LD_E`/`CMD_LD_N`/`CMD_START`;
  - the FSM state encoding;
  - `WORDS` = 16.
- Internal counter: 5 bits, reused for FLUSH, FEED and the WAIT_VLD timeout.
- No sub-module inside this block. The existing `seq_to_para` is instantiated alongside it at the next level up.

## Test plan
- **Reset release** → `cmd_ready` stays 0 for 18 cycles, then goes to 1; all outputs are 0.
- **Load N** with words 0x00000001..0x00000010 → `op_n` = 0x00000010_0000000F_…_00000001 in T+19; `op_m` and `op_e` unchanged.
- **Start after loading M=2, E=3, N=5**; model returns `core_res` = 3 with `core_done` 10 cycles after `core_start` → `res` = 3 and `res_vld` = 1 one cycle later; `res_vld` clears on the next accepted command.
- **Start with only M and E loaded** → `err` pulses in T+2, no `core_start`, `cmd_ready` high in T+3.
- **Deserializer model withholds `des_vld`** → `err` pulses 5 cycles after the expected T+18; `op_x` unchanged; flag stays clear.
- **Assert `rst` in FEED cycle 7** → `data_req` drops the next cycle, FLUSH lasts 18 cycles, and a fresh load then completes correctly.
